// File: rtl/g2b_serial_ctrl.sv
// Bit-serial Gray-to-binary converter. A single XOR stage walks the captured
// word MSB first, one bit per clock, behind valid/ready handshakes on both sides.
module g2b_serial_ctrl #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] b,
    output logic         busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  greg;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          t;

    assign t = acc ^ greg[cnt];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)         state_nxt = CONV;
            CONV:    if (cnt == '0)        state_nxt = HOLD;
            HOLD:    if (out_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Handshake flags decode state alone, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            greg <= '0;
            cnt  <= '0;
            acc  <= 1'b0;
            b    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    greg <= g;
                    cnt  <= CW'(N - 1);
                    acc  <= 1'b0;
                    b    <= '0;
                end
                CONV: begin
                    acc    <= t;
                    b[cnt] <= t;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_g2b_serial_ctrl.sv
// Directed bench for g2b_serial_ctrl at N=10: hand-derived Gray/binary pairs,
// handshake timing, back-pressure, reset abort and back-to-back accept spacing.
module tb_g2b_serial_ctrl;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] g;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] b;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_q[$];

    g2b_serial_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .g(g),
        .out_valid(out_valid), .out_ready(out_ready), .b(b), .busy(busy)
    );

    always #5 clk = ~clk;

    // Log the cycle number of every accept edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [N-1:0] gw, input logic [N-1:0] bw);
        g = gw; in_valid = 1'b1; out_ready = 1'b1;
        step();                                    // accept edge T
        in_valid = 1'b0; g = '0;
        chk({tag, "_busy_after_accept"}, N'(busy), N'(1));
        chk({tag, "_inrdy_after_accept"}, N'(in_ready), N'(0));
        step(N - 1);                               // T+N-1
        chk({tag, "_no_early_valid"}, N'(out_valid), N'(0));
        step();                                    // T+N
        chk({tag, "_out_valid"}, N'(out_valid), N'(1));
        chk({tag, "_b"}, b, bw);
        step();                                    // T+N+1 handshake
        chk({tag, "_idle_busy"}, N'(busy), N'(0));
        chk({tag, "_idle_inrdy"}, N'(in_ready), N'(1));
        chk({tag, "_b_kept"}, b, bw);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; g = '0;
        step(2);
        rst = 1'b0;
        chk("rst_in_ready", N'(in_ready), N'(1));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_out_valid", N'(out_valid), N'(0));
        chk("rst_b", b, '0);

        convert("single", 10'b0100100100, 10'b0111000111);

        // back-pressure: hold HOLD for 5 cycles
        g = 10'b1000001001; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(N);
        chk("bp_valid", N'(out_valid), N'(1));
        chk("bp_b", b, 10'b1111110001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stall_valid", N'(out_valid), N'(1));
            chk("bp_stall_b", b, 10'b1111110001);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle", N'(in_ready), N'(1));
        chk("bp_idle_valid", N'(out_valid), N'(0));

        // new word offered throughout CONV/HOLD must be ignored
        g = 10'b1111111111; in_valid = 1'b1; out_ready = 1'b1;
        step();
        g = 10'b0000000000;
        for (int i = 0; i < N; i++) begin
            chk("ign_in_ready_low", N'(in_ready), N'(0));
            step();
        end
        chk("ign_valid", N'(out_valid), N'(1));
        chk("ign_b", b, 10'b1010101010);
        step();
        chk("ign_back_idle", N'(in_ready), N'(1));
        step();
        in_valid = 1'b0;
        chk("ign_second_accept", N'(busy), N'(1));
        chk("ign_b_cleared", b, '0);
        step(N);
        chk("ign_second_b", b, 10'b0000000000);
        chk("ign_second_valid", N'(out_valid), N'(1));
        step();

        // reset four edges into a conversion
        g = 10'b1001100011; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(3);
        chk("rstmid_no_valid", N'(out_valid), N'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_b", b, '0);
        chk("rstmid_busy", N'(busy), N'(0));
        chk("rstmid_in_ready", N'(in_ready), N'(1));
        for (int i = 0; i < N + 2; i++) begin
            step();
            chk("rstmid_never_valid", N'(out_valid), N'(0));
        end
        convert("rstmid_next", 10'b1100001101, 10'b1000001001);

        // back-to-back with both handshakes held high
        acc_q.delete();
        g = 10'b0001100101; in_valid = 1'b1; out_ready = 1'b1;
        step();
        g = 10'b1000010010;
        step(N);
        chk("b2b_first_b", b, 10'b0001000110);
        step(2);
        step(N);
        chk("b2b_second_b", b, 10'b1111100011);
        in_valid = 1'b0;
        step();
        chk("b2b_accepts", N'(acc_q.size()), N'(2));
        if (acc_q.size() >= 2) chk("b2b_spacing", N'(acc_q[1] - acc_q[0]), N'(12));

        convert("zero", 10'b0000000000, 10'b0000000000);
        convert("msb", 10'b1000000000, 10'b1111111111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
